// File: rtl/step_pulse_gen.sv
//------------------------------------------------------------------------------
// step_pulse_gen
// Two-channel lockstep step/direction pulse generator for stepper drivers.
// A load in IDLE captures step counts and directions, waits a direction
// setup time, then issues one pulse per period on each channel that still
// has steps left, and reports completion with a one-cycle done pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_pulse_gen #(
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_HIGH  = 500,
  parameter int DIR_SETUP   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [8:0] steps1,
  input  logic [8:0] steps2,
  input  logic       dir1,
  input  logic       dir2,
  output logic       step1_out,
  output logic       step2_out,
  output logic       dir1_out,
  output logic       dir2_out,
  output logic       busy,
  output logic       done,
  output logic [8:0] remaining1,
  output logic [8:0] remaining2
);

  // Counter widths sized so the largest compared value always fits.
  localparam int PW = $clog2(STEP_PERIOD + 1);
  localparam int SW = $clog2(DIR_SETUP + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(STEP_PERIOD - 1);
  localparam logic [PW-1:0] HIGH_END    = PW'(PULSE_HIGH);
  localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
  localparam logic [SW-1:0] SETUP_LAST  = SW'(DIR_SETUP - 1);
  localparam logic [SW-1:0] SETUP_ONE   = SW'(1);
  localparam logic [8:0]    STEP_ONE    = 9'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [SW-1:0] setup_cnt;
  // DONE spans two cycles: the first lets busy drop after the last falling
  // edge, the second carries the done pulse. Loads are ignored in both.
  logic          done_phase;

  // Move sequencer: command capture, setup delay, lockstep pulsing, completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      setup_cnt  <= '0;
      done_phase <= 1'b0;
      step1_out  <= 1'b0;
      step2_out  <= 1'b0;
      dir1_out   <= 1'b0;
      dir2_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining1 <= '0;
      remaining2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            remaining1 <= steps1;
            remaining2 <= steps2;
            dir1_out   <= dir1;
            dir2_out   <= dir2;
            setup_cnt  <= '0;
            period_cnt <= '0;
            done_phase <= 1'b0;
            if ((steps1 == 9'd0) && (steps2 == 9'd0)) begin
              // Nothing to move: report completion without ever going busy.
              state <= DONE;
            end else begin
              state <= SETUP;
              busy  <= 1'b1;
            end
          end
        end

        SETUP: begin
          // Direction lines are stable; hold step low for DIR_SETUP cycles.
          if (setup_cnt == SETUP_LAST) begin
            state      <= RUN;
            period_cnt <= '0;
          end else begin
            setup_cnt <= setup_cnt + SETUP_ONE;
          end
        end

        RUN: begin
          if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
          end else begin
            period_cnt <= period_cnt + PERIOD_ONE;
          end

          if (period_cnt == '0) begin
            // Start of a period: each channel with work left fires a pulse.
            if (remaining1 != 9'd0) begin
              step1_out  <= 1'b1;
              remaining1 <= remaining1 - STEP_ONE;
            end
            if (remaining2 != 9'd0) begin
              step2_out  <= 1'b1;
              remaining2 <= remaining2 - STEP_ONE;
            end
          end else if (period_cnt == HIGH_END) begin
            step1_out <= 1'b0;
            step2_out <= 1'b0;
            // The falling edge of the longer channel's last pulse ends the run.
            if ((remaining1 == 9'd0) && (remaining2 == 9'd0)) begin
              state      <= DONE;
              done_phase <= 1'b0;
              period_cnt <= '0;
            end
          end
        end

        DONE: begin
          if (!done_phase) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            done_phase <= 1'b1;
          end else begin
            done       <= 1'b0;
            done_phase <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
//------------------------------------------------------------------------------
// tb_step_pulse_gen
// Scoreboard bench for step_pulse_gen: the driver predicts pulse rise times,
// remaining counts and done times from the move rules; a monitor on the
// falling clock edge pops and compares whenever the DUT shows an event.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_pulse_gen;

  localparam int SP = 10;
  localparam int PH = 3;
  localparam int DS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [8:0] steps1, steps2;
  logic       dir1, dir2;
  logic       step1_out, step2_out, dir1_out, dir2_out, busy, done;
  logic [8:0] remaining1, remaining2;

  step_pulse_gen #(
    .STEP_PERIOD(SP),
    .PULSE_HIGH (PH),
    .DIR_SETUP  (DS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .steps1    (steps1),
    .steps2    (steps2),
    .dir1      (dir1),
    .dir2      (dir2),
    .step1_out (step1_out),
    .step2_out (step2_out),
    .dir1_out  (dir1_out),
    .dir2_out  (dir2_out),
    .busy      (busy),
    .done      (done),
    .remaining1(remaining1),
    .remaining2(remaining2)
  );

  always #5 clk = ~clk;

  // Edge index: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int rem;
    int dir;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  int  qd[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  last_done = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference model: pulse i of a channel rises DS+1+i*SP edges after load;
  // the move ends one edge after the longest channel's last pulse falls.
  task automatic plan_move(input int e0, input int n1, input int d1,
                           input int n2, input int d2);
    int  first;
    int  nmax;
    ev_t e;
    first = e0 + DS + 1;
    nmax  = (n1 > n2) ? n1 : n2;
    for (int i = 0; i < n1; i++) begin
      e.t = first + i * SP; e.rem = n1 - 1 - i; e.dir = d1;
      q1.push_back(e);
    end
    for (int i = 0; i < n2; i++) begin
      e.t = first + i * SP; e.rem = n2 - 1 - i; e.dir = d2;
      q2.push_back(e);
    end
    if (nmax == 0) last_done = e0 + 1;
    else           last_done = first + (nmax - 1) * SP + PH + 1;
    qd.push_back(last_done);
  endtask

  // Called at a falling edge; the load is sampled on the next rising edge.
  task automatic do_load(input int n1, input int d1, input int n2, input int d2);
    int e0;
    steps1 = 9'(n1); steps2 = 9'(n2);
    dir1 = (d1 != 0); dir2 = (d2 != 0);
    load = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    load = 1'b0;
    plan_move(e0, n1, d1, n2, d2);
    chk("dir1_out after load", int'(dir1_out), d1);
    chk("dir2_out after load", int'(dir2_out), d2);
    chk("busy after load", int'(busy), ((n1 != 0) || (n2 != 0)) ? 1 : 0);
    chk("remaining1 after load", int'(remaining1), n1);
    chk("remaining2 after load", int'(remaining2), n2);
  endtask

  // A load that must be ignored: nothing observable may change at its edge.
  task automatic ign_load(input int n1, input int d1, input int n2, input int d2);
    int r1, r2, o1, o2, b;
    r1 = remaining1; r2 = remaining2; o1 = dir1_out; o2 = dir2_out; b = busy;
    steps1 = 9'(n1); steps2 = 9'(n2);
    dir1 = (d1 != 0); dir2 = (d2 != 0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ignored load remaining1", int'(remaining1), r1);
    chk("ignored load remaining2", int'(remaining2), r2);
    chk("ignored load dir1_out", int'(dir1_out), o1);
    chk("ignored load dir2_out", int'(dir2_out), o2);
    chk("ignored load busy", int'(busy), b);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: pop and compare on every step rise and done pulse.
  logic p1 = 1'b0, p2 = 1'b0, pd = 1'b0;
  int   r1t = 0, r2t = 0, dlen = 0;
  ev_t  me;
  int   mt;
  always @(negedge clk) begin
    if (reset) begin
      p1 = 1'b0; p2 = 1'b0; pd = 1'b0; dlen = 0;
    end else begin
      if (step1_out && !p1) begin
        if (q1.size() == 0) chk("ch1 unexpected rise, queued events", 0, 1);
        else begin
          me = q1.pop_front();
          chk("ch1 rise time", cyc, me.t);
          chk("ch1 remaining at rise", int'(remaining1), me.rem);
          chk("ch1 dir at rise", int'(dir1_out), me.dir);
          chk("busy at ch1 rise", int'(busy), 1);
        end
        r1t = cyc;
      end
      if (!step1_out && p1) chk("ch1 pulse width", cyc - r1t, PH);
      if (step2_out && !p2) begin
        if (q2.size() == 0) chk("ch2 unexpected rise, queued events", 0, 1);
        else begin
          me = q2.pop_front();
          chk("ch2 rise time", cyc, me.t);
          chk("ch2 remaining at rise", int'(remaining2), me.rem);
          chk("ch2 dir at rise", int'(dir2_out), me.dir);
          chk("busy at ch2 rise", int'(busy), 1);
        end
        r2t = cyc;
      end
      if (!step2_out && p2) chk("ch2 pulse width", cyc - r2t, PH);
      if (done && !pd) begin
        if (qd.size() == 0) chk("unexpected done, queued events", 0, 1);
        else begin
          mt = qd.pop_front();
          chk("done time", cyc, mt);
          chk("busy at done", int'(busy), 0);
          chk("remaining1 at done", int'(remaining1), 0);
          chk("remaining2 at done", int'(remaining2), 0);
          chk("ch1 pulses left at done", q1.size(), 0);
          chk("ch2 pulses left at done", q2.size(), 0);
        end
      end
      if (done) dlen++;
      else if (pd) begin
        chk("done width", dlen, 1);
        dlen = 0;
      end
      p1 = step1_out; p2 = step2_out; pd = done;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, " step1_out"}, int'(step1_out), 0);
    chk({tag, " step2_out"}, int'(step2_out), 0);
    chk({tag, " dir1_out"}, int'(dir1_out), 0);
    chk({tag, " dir2_out"}, int'(dir2_out), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " remaining1"}, int'(remaining1), 0);
    chk({tag, " remaining2"}, int'(remaining2), 0);
  endtask

  initial begin
    int n1, n2, d1, d2, k;
    reset = 1'b1; load = 1'b0;
    steps1 = '0; steps2 = '0; dir1 = 1'b0; dir2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Reference move with a second load that must be ignored mid-run.
    begin
      int e0;
      e0 = cyc + 1;
      do_load(3, 1, 5, 0);
      wait_until(e0 + 19);
      ign_load(9, 0, 9, 1);
      chk("remaining1 after ignored load", int'(remaining1), 1);
      wait_until(last_done + 1);
    end

    // All-zero move: done only, never busy.
    do_load(0, 1, 0, 1);
    wait_until(last_done + 1);

    // Randomised moves with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      n1 = $urandom_range(0, 6); n2 = $urandom_range(0, 6);
      d1 = $urandom_range(0, 1); d2 = $urandom_range(0, 1);
      do_load(n1, d1, n2, d2);
      wait_until(last_done + 1 + $urandom_range(0, 3));
    end

    // Load during the done cycle is ignored; the next cycle's load is taken.
    do_load(2, 0, 1, 1);
    wait_until(last_done);
    ign_load(4, 1, 4, 0);
    do_load(2, 1, 1, 0);
    wait_until(last_done + 1);

    // Asynchronous reset while a pulse is high aborts the move.
    do_load(4, 1, 3, 1);
    k = 0;
    while (!step1_out && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    chk("step1_out high before reset", int'(step1_out), 1);
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    q1.delete(); q2.delete(); qd.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_load(2, 0, 0, 0);
    wait_until(last_done + 1);

    // Full-range count: 511 pulses with no wrap below zero.
    do_load(511, 1, 1, 1);
    wait_until(last_done + 2);

    repeat (5) @(negedge clk);
    chk("ch1 events outstanding", q1.size(), 0);
    chk("ch2 events outstanding", q2.size(), 0);
    chk("done events outstanding", qd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
